// File: rtl/div_unsigned_seq.sv
// Iterative radix-2 restoring unsigned divider, one quotient bit per clock.
// Valid/ready handshake on operands and on the quotient/remainder result.
module div_unsigned_seq #(
  parameter int WIDTHA = 20,
  parameter int WIDTHB = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTHA-1:0] A,
  input  logic [WIDTHB-1:0] B,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTHA-1:0] Q,
  output logic [WIDTHB-1:0] R,
  output logic              div_by_zero
);

  localparam int CW = $clog2(WIDTHA);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [WIDTHA-1:0] a_q, a_d;
  logic [WIDTHB-1:0] b_q, b_d;
  logic [WIDTHB-1:0] pr_q, pr_d;
  logic [WIDTHA-1:0] q_q, q_d;
  logic [WIDTHB-1:0] r_q, r_d;
  logic              dz_q, dz_d;
  logic [WIDTHB:0]   pr_sh;
  logic              geq;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      pr_q    <= '0;
      q_q     <= '0;
      r_q     <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      pr_q    <= pr_d;
      q_q     <= q_d;
      r_q     <= r_d;
      dz_q    <= dz_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    a_d       = a_q;
    b_d       = b_q;
    pr_d      = pr_q;
    q_d       = q_q;
    r_d       = r_q;
    dz_d      = dz_q;
    in_ready  = (state_q == IDLE) && !rst;
    out_valid = (state_q == DONE);
    // Stored remainder is always < B; only the shifted value needs WIDTHB+1.
    pr_sh     = {pr_q, a_q[WIDTHA-1]};
    geq       = (pr_sh >= {1'b0, b_q});
    unique case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          a_d  = A;
          b_d  = B;
          pr_d = '0;
          if (B == '0) begin
            q_d     = '1;
            r_d     = A[WIDTHB-1:0];
            dz_d    = 1'b1;
            state_d = DONE;
          end else begin
            dz_d    = 1'b0;
            cnt_d   = CW'(WIDTHA - 1);
            state_d = RUN;
          end
        end
      end
      RUN: begin
        pr_d  = geq ? WIDTHB'(pr_sh - {1'b0, b_q})
                    : pr_sh[WIDTHB-1:0];
        a_d   = {a_q[WIDTHA-2:0], geq};
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          cnt_d   = '0;
          q_d     = a_d;
          r_d     = pr_d;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign Q           = q_q;
  assign R           = r_q;
  assign div_by_zero = dz_q;

endmodule

// File: tb/tb_div_unsigned_seq.sv
// Scoreboard bench for div_unsigned_seq: latency, results,
// back-pressure, reset mid-run and a random sweep.
module tb_div_unsigned_seq;

  localparam int WA = 20;
  localparam int WB = 12;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [WA-1:0] A = '0;
  logic [WB-1:0] B = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [WA-1:0] Q;
  logic [WB-1:0] R;
  logic          div_by_zero;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [WA-1:0] a;
    logic [WB-1:0] b;
    logic [WA-1:0] q;
    logic [WB-1:0] r;
    logic          dz;
    int            lat;
  } exp_t;

  exp_t sb[$];

  div_unsigned_seq #(.WIDTHA(WA), .WIDTHB(WB)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .A          (A),
    .B          (B),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .Q          (Q),
    .R          (R),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic issue(input logic [WA-1:0] a, input logic [WB-1:0] b);
    exp_t e;
    @(negedge clk);
    in_valid = 1'b1;
    A = a;
    B = b;
    e.a = a;
    e.b = b;
    if (b == '0) begin
      e.q = '1;
      e.r = a[WB-1:0];
      e.dz = 1'b1;
      e.lat = 0;
    end else begin
      e.q = a / WA'(b);
      e.r = WB'(a % WA'(b));
      e.dz = 1'b0;
      e.lat = WA;
    end
    sb.push_back(e);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // lat = rising edges after the acceptance edge until out_valid is seen
  task automatic wait_out(output int lat, output bit to);
    bit fin;
    lat = 0;
    to = 0;
    fin = 0;
    while (!fin) begin
      @(negedge clk);
      if (out_valid) fin = 1;
      else if (lat >= 64) begin
        to = 1;
        fin = 1;
      end else begin
        @(posedge clk);
        lat++;
      end
    end
  endtask

  task automatic handshake();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    tests++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || Q !== '0 ||
        R !== '0 || div_by_zero !== 1'b0) begin
      fails++;
      $display("FAIL reset_state: rdy=%b vld=%b Q=%h R=%h dz=%b want 0",
               in_ready, out_valid, Q, R, div_by_zero);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL idle_after_reset: rdy=%b vld=%b want 1/0",
               in_ready, out_valid);
    end
  endtask

  task automatic test_basic();
    int lat;
    bit to;
    exp_t e;
    issue(20'd1000000, 12'd1234);
    wait_out(lat, to);
    e = sb.pop_front();
    tests++;
    if (to || lat != 20) begin
      fails++;
      $display("FAIL basic_latency: got %0d (timeout=%0d) want 20", lat, to);
    end
    tests++;
    if (Q !== 20'd810 || R !== 12'd460 || div_by_zero !== 1'b0) begin
      fails++;
      $display("FAIL basic_result: Q=%0d R=%0d dz=%b want 810 460 0",
               Q, R, div_by_zero);
    end
    tests++;
    if (Q !== e.q || R !== e.r) begin
      fails++;
      $display("FAIL basic_model: Q=%0d R=%0d want %0d %0d", Q, R, e.q, e.r);
    end
    handshake();
    @(negedge clk);
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL basic_release: vld=%b rdy=%b want 0/1",
               out_valid, in_ready);
    end
  endtask

  task automatic test_boundary();
    logic [WA-1:0] ta [3];
    logic [WB-1:0] tb [3];
    int lat;
    bit to;
    exp_t e;
    ta[0] = 20'hFFFFF; tb[0] = 12'd1;
    ta[1] = 20'hFFFFF; tb[1] = 12'd4095;
    ta[2] = 20'd100;   tb[2] = 12'd4095;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      issue(ta[i], tb[i]);
      wait_out(lat, to);
      e = sb.pop_front();
      tests++;
      if (to || lat != e.lat || Q !== e.q || R !== e.r ||
          div_by_zero !== 1'b0) begin
        fails++;
        $display("FAIL boundary_%0d: lat=%0d Q=%h R=%h dz=%b want %0d %h %h 0",
                 i, lat, Q, R, div_by_zero, e.lat, e.q, e.r);
      end
      @(posedge clk);
      #1;
    end
    out_ready = 1'b0;
    tests++;
    if (ta[0] / WA'(tb[1]) != 256) begin
      fails++;
      $display("FAIL boundary_model: model %0d want 256", ta[0] / WA'(tb[1]));
    end
  endtask

  task automatic test_div_zero();
    int lat;
    bit to;
    exp_t e;
    issue(20'd12345, 12'd0);
    wait_out(lat, to);
    e = sb.pop_front();
    tests++;
    if (to || lat != 0) begin
      fails++;
      $display("FAIL dz_latency: got %0d edges want 0 (next cycle)", lat);
    end
    tests++;
    if (Q !== 20'hFFFFF || R !== 12'h039 || div_by_zero !== 1'b1) begin
      fails++;
      $display("FAIL dz_result: Q=%h R=%h dz=%b want fffff 039 1",
               Q, R, div_by_zero);
    end
    tests++;
    if (Q !== e.q || R !== e.r) begin
      fails++;
      $display("FAIL dz_model: Q=%h R=%h want %h %h", Q, R, e.q, e.r);
    end
    handshake();
  endtask

  task automatic test_backpressure();
    int lat;
    bit to;
    exp_t e;
    int bad;
    issue(20'h54321, 12'h0AB);
    wait_out(lat, to);
    e = sb.pop_front();
    tests++;
    if (to) begin
      fails++;
      $display("FAIL bp_wait: out_valid=0 want 1");
    end
    bad = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (i == 3) begin
        in_valid = 1'b1;
        A = 20'd9;
        B = 12'd2;
      end
      if (i == 8) in_valid = 1'b0;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 ||
          Q !== e.q || R !== e.r || div_by_zero !== 1'b0) bad++;
    end
    in_valid = 1'b0;
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL bp_hold: %0d bad cycles, Q=%h R=%h want %h %h",
               bad, Q, R, e.q, e.r);
    end
    handshake();
    @(negedge clk);
    tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL bp_release: rdy=%b vld=%b want 1/0", in_ready, out_valid);
    end
    bad = 0;
    repeat (25) begin
      @(negedge clk);
      if (out_valid !== 1'b0) bad++;
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL bp_ignored_op: out_valid high %0d cycles want 0", bad);
    end
  endtask

  task automatic test_reset_mid_run();
    int lat;
    bit to;
    int bad;
    exp_t e;
    out_ready = 1'b1;
    issue(20'd777777, 12'd99);
    out_ready = 1'b0;
    repeat (6) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    tests++;
    if (out_valid !== 1'b0 || Q !== '0 || R !== '0 ||
        div_by_zero !== 1'b0 || in_ready !== 1'b0) begin
      fails++;
      $display("FAIL midrun_clear: vld=%b Q=%h R=%h dz=%b rdy=%b want 0",
               out_valid, Q, R, div_by_zero, in_ready);
    end
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    bad = 0;
    repeat (30) begin
      @(negedge clk);
      if (out_valid !== 1'b0) bad++;
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL midrun_discard: out_valid high %0d cycles want 0", bad);
    end
    issue(20'd500, 12'd7);
    wait_out(lat, to);
    e = sb.pop_front();
    tests++;
    if (to || lat != 20 || Q !== 20'd71 || R !== 12'd3 ||
        Q !== e.q || R !== e.r) begin
      fails++;
      $display("FAIL midrun_fresh: lat=%0d Q=%0d R=%0d want 20 71 3",
               lat, Q, R);
    end
    handshake();
  endtask

  task automatic test_random();
    int lat;
    bit to;
    exp_t e;
    int bad;
    logic [WA-1:0] ra;
    logic [WB-1:0] rb;
    bad = 0;
    for (int i = 0; i < 2000; i++) begin
      ra = WA'($urandom);
      rb = ($urandom_range(0, 15) == 0) ? '0 : WB'($urandom);
      if (i % 7 == 1) rb = WB'($urandom_range(1, 3));
      issue(ra, rb);
      wait_out(lat, to);
      e = sb.pop_front();
      if (to || lat != e.lat || Q !== e.q || R !== e.r ||
          div_by_zero !== e.dz) begin
        bad++;
        if (bad < 5)
          $display("FAIL rand_%0d: A=%h B=%h lat=%0d Q=%h R=%h dz=%b want %0d %h %h %b",
                   i, ra, rb, lat, Q, R, div_by_zero, e.lat, e.q, e.r, e.dz);
      end else if (rb != '0 &&
                   (32'(ra) != 32'(Q) * 32'(rb) + 32'(R) || R >= rb)) begin
        bad++;
        if (bad < 5)
          $display("FAIL rand_identity_%0d: A=%h B=%h Q=%h R=%h", i, ra, rb, Q, R);
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
      handshake();
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL rand_sweep: %0d bad results want 0", bad);
    end
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_empty: %0d left want 0", sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_boundary();
    test_div_zero();
    test_backpressure();
    test_reset_mid_run();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
